// File: rtl/snes_clk_pkg.sv
// Shared state encoding and timing defaults for the SNES reset sequencer.
// The debug overlay decodes state_dbg using state_e from here.
package snes_clk_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LOCK  = 3'd1,
    SDRAM_INIT = 3'd2,
    CORE_HOLD  = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_DEBOUNCE_CYCLES    = 65536;
  localparam int DEF_INIT_TIMEOUT       = 1000000;
  localparam int DEF_CORE_HOLD_CYCLES   = 16;
  localparam int DEF_FAULT_RETRY_CYCLES = 4096;

  typedef struct packed {
    logic       req;
    logic       core_resetn;
    logic       ready;
    logic       fault;
    logic [2:0] state_dbg;
  } seq_out_t;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Output levels implied by a state; registered by the sequencer.
  function automatic seq_out_t decode(state_e s);
    seq_out_t o;
    o           = '0;
    o.state_dbg = s;
    case (s)
      SDRAM_INIT: o.req = 1'b1;
      RUN: begin
        o.core_resetn = 1'b1;
        o.ready       = 1'b1;
      end
      FAULT:      o.fault = 1'b1;
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snes_reset_seq_if.sv
// Lock/button/SDRAM handshake and status bundle around the reset sequencer.
interface snes_reset_seq_if;
  logic       pll_lock;
  logic       btn_reset;
  logic       sdram_init_done;
  logic       sdram_init_req;
  logic       core_resetn;
  logic       ready;
  logic       fault;
  logic [2:0] state_dbg;

  modport master (
    input  pll_lock, btn_reset, sdram_init_done,
    output sdram_init_req, core_resetn, ready, fault, state_dbg
  );

  modport slave (
    output pll_lock, btn_reset, sdram_init_done,
    input  sdram_init_req, core_resetn, ready, fault, state_dbg
  );
endinterface

// File: rtl/sync_debounce.sv
// 2-flop synchroniser followed by a steady-count filter; level and rise pulse
// change together once the input has differed for DEBOUNCE_CYCLES samples.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/snes_reset_seq.sv
// Power-up/reset sequencer: waits for stable PLL lock, handshakes SDRAM init,
// then releases the SNES core; re-sequences on lock loss, button press or init timeout.
module snes_reset_seq
  import snes_clk_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int INIT_TIMEOUT       = DEF_INIT_TIMEOUT,
  parameter int CORE_HOLD_CYCLES   = DEF_CORE_HOLD_CYCLES,
  parameter int FAULT_RETRY_CYCLES = DEF_FAULT_RETRY_CYCLES
) (
  input  logic              clk,
  input  logic              resetn,
  snes_reset_seq_if.master  bus
);
  localparam int CW = $clog2(imax(imax(LOCK_STABLE_CYCLES, INIT_TIMEOUT),
                                  imax(CORE_HOLD_CYCLES, FAULT_RETRY_CYCLES))) + 1;

  logic [1:0]    lk_sync;
  logic          lk, db, press, abort;
  state_e        state;
  logic [CW-1:0] dwell, lock_cnt;
  seq_out_t      outs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lk_sync <= '0;
    else         lk_sync <= {lk_sync[0], bus.pll_lock};
  end
  assign lk = lk_sync[1];

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .resetn (resetn),
    .din    (bus.btn_reset),
    .level  (db),
    .rise   (press)
  );

  // Lock loss or a button press restarts from WAIT_LOCK from any active state.
  assign abort = (state != IDLE) && (!lk || press);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      dwell    <= '0;
      lock_cnt <= '0;
      outs     <= '0;
    end else begin
      // Aborts pull outputs to their WAIT_LOCK levels on the same edge as the state.
      outs  <= decode(abort ? WAIT_LOCK : state);
      dwell <= (&dwell) ? dwell : dwell + 1'b1;
      if (abort) begin
        state    <= WAIT_LOCK;
        dwell    <= '0;
        lock_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_LOCK;
            dwell <= '0;
          end
          WAIT_LOCK: begin
            // A held button keeps the lock count parked at zero.
            if (db) begin
              lock_cnt <= '0;
            end else if (lock_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
              state    <= SDRAM_INIT;
              dwell    <= '0;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= (&lock_cnt) ? lock_cnt : lock_cnt + 1'b1;
            end
          end
          SDRAM_INIT: begin
            // dwell==0 is the entry cycle: done may still be stale from a previous init.
            if (dwell != '0 && bus.sdram_init_done) begin
              state <= CORE_HOLD;
              dwell <= '0;
            end else if (dwell >= CW'(INIT_TIMEOUT - 1)) begin
              state <= FAULT;
              dwell <= '0;
            end
          end
          CORE_HOLD: begin
            if (dwell >= CW'(CORE_HOLD_CYCLES - 1)) begin
              state <= RUN;
              dwell <= '0;
            end
          end
          RUN: ;
          FAULT: begin
            if (dwell >= CW'(FAULT_RETRY_CYCLES - 1)) begin
              state <= WAIT_LOCK;
              dwell <= '0;
            end
          end
          default: begin
            state <= IDLE;
            dwell <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sdram_init_req = outs.req;
  assign bus.core_resetn    = outs.core_resetn;
  assign bus.ready          = outs.ready;
  assign bus.fault          = outs.fault;
  assign bus.state_dbg      = outs.state_dbg;

endmodule

// File: tb/tb_snes_reset_seq.sv
// Directed bench for snes_reset_seq with small timing parameters
// (lock 8, debounce 4, timeout 50, hold 3, retry 10).
module tb_snes_reset_seq;
  localparam int SEL_REQ   = 0;
  localparam int SEL_READY = 1;
  localparam int SEL_FAULT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  snes_reset_seq_if bus ();

  snes_reset_seq #(
    .LOCK_STABLE_CYCLES (8),
    .DEBOUNCE_CYCLES    (4),
    .INIT_TIMEOUT       (50),
    .CORE_HOLD_CYCLES   (3),
    .FAULT_RETRY_CYCLES (10)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_REQ:   return bus.sdram_init_req;
      SEL_READY: return bus.ready;
      default:   return bus.fault;
    endcase
  endfunction

  // Steps until the selected output reaches lvl; n = edges taken (bound if never).
  task automatic wait_level(input int sel, input logic lvl, input int bound, output int n);
    n = 0;
    while (n < bound && sig(sel) !== lvl) begin
      step(1);
      n++;
    end
  endtask

  // Reset released #1 after an edge; the next posedge is edge 1.
  task automatic apply_reset(input logic done_lvl);
    resetn              = 1'b0;
    bus.pll_lock        = 1'b1;
    bus.btn_reset       = 1'b0;
    bus.sdram_init_done = done_lvl;
    step(3);
    resetn = 1'b1;
  endtask

  task automatic bring_up(output logic ok);
    int n;
    apply_reset(1'b0);
    wait_level(SEL_REQ, 1'b1, 40, n);
    step(2);
    bus.sdram_init_done = 1'b1;
    wait_level(SEL_READY, 1'b1, 40, n);
    ok = bus.ready;
  endtask

  task automatic test_reset;
    resetn              = 1'b0;
    bus.pll_lock        = 1'b1;
    bus.btn_reset       = 1'b0;
    bus.sdram_init_done = 1'b0;
    step(3);
    tests++; if (bus.sdram_init_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.sdram_init_req); end
    tests++; if (bus.core_resetn !== 1'b0) begin fails++; $display("FAIL reset_core_resetn: got %b want 0", bus.core_resetn); end
    tests++; if ({bus.ready, bus.fault} !== 2'b00) begin fails++; $display("FAIL reset_ready_fault: got %b want 00", {bus.ready, bus.fault}); end
    tests++; if (bus.state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
  endtask

  task automatic test_power_up;
    int n;
    apply_reset(1'b0);
    wait_level(SEL_REQ, 1'b1, 40, n);
    // 2 sync + 8 lock-stable edges, then the output register.
    tests++; if (n !== 11) begin fails++; $display("FAIL pwr_req_latency: got %0d want 11", n); end
    tests++; if (bus.state_dbg !== 3'd2) begin fails++; $display("FAIL pwr_state_init: got %0d want 2", bus.state_dbg); end
    step(5);
    bus.sdram_init_done = 1'b1;
    wait_level(SEL_READY, 1'b1, 40, n);
    // done sampled on the first edge, then HOLD+1 more edges to ready.
    tests++; if (n !== 5) begin fails++; $display("FAIL pwr_ready_latency: got %0d want 5", n); end
    tests++; if (bus.core_resetn !== 1'b1) begin fails++; $display("FAIL pwr_core_resetn: got %b want 1", bus.core_resetn); end
    tests++; if (bus.state_dbg !== 3'd4) begin fails++; $display("FAIL pwr_state_run: got %0d want 4", bus.state_dbg); end
    tests++; if (bus.sdram_init_req !== 1'b0) begin fails++; $display("FAIL pwr_req_dropped: got %b want 0", bus.sdram_init_req); end
  endtask

  task automatic test_lock_glitch;
    int n;
    apply_reset(1'b0);
    step(5);
    bus.pll_lock = 1'b0;
    step(1);
    bus.pll_lock = 1'b1;
    wait_level(SEL_REQ, 1'b1, 40, n);
    // Glitch seen at count 5 on edge 8; recount 9..16, req at edge 17.
    tests++; if (n !== 11) begin fails++; $display("FAIL glitch_req_latency: got %0d want 11", n); end
  endtask

  task automatic test_lock_loss;
    int   n;
    logic ok;
    bring_up(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL loss_bring_up: got %b want 1", ok); end
    bus.pll_lock = 1'b0;
    step(2);
    tests++; if (bus.core_resetn !== 1'b1) begin fails++; $display("FAIL loss_still_synced: got %b want 1", bus.core_resetn); end
    step(1);
    tests++; if ({bus.core_resetn, bus.ready} !== 2'b00) begin fails++; $display("FAIL loss_abort: got %b want 00", {bus.core_resetn, bus.ready}); end
    bus.sdram_init_done = 1'b0;
    bus.pll_lock        = 1'b1;
    wait_level(SEL_REQ, 1'b1, 40, n);
    tests++; if (n !== 11) begin fails++; $display("FAIL loss_reseq_req: got %0d want 11", n); end
    step(5);
    bus.sdram_init_done = 1'b1;
    wait_level(SEL_READY, 1'b1, 40, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL loss_reseq_ready: got %0d want 5", n); end
  endtask

  task automatic test_init_timeout;
    int   n;
    logic req_seen;
    apply_reset(1'b0);
    wait_level(SEL_REQ, 1'b1, 40, n);
    wait_level(SEL_FAULT, 1'b1, 80, n);
    tests++; if (n !== 50) begin fails++; $display("FAIL timeout_fault_at: got %0d want 50", n); end
    tests++; if (bus.sdram_init_req !== 1'b0) begin fails++; $display("FAIL timeout_req_in_fault: got %b want 0", bus.sdram_init_req); end
    n = 0;
    req_seen = 1'b0;
    while (n < 30 && bus.fault !== 1'b0) begin
      if (bus.sdram_init_req !== 1'b0) req_seen = 1'b1;
      step(1);
      n++;
    end
    tests++; if (n !== 10) begin fails++; $display("FAIL timeout_retry_dwell: got %0d want 10", n); end
    tests++; if (req_seen !== 1'b0) begin fails++; $display("FAIL timeout_req_during_fault: got %b want 0", req_seen); end
    tests++; if (bus.state_dbg !== 3'd1) begin fails++; $display("FAIL timeout_back_to_wait: got %0d want 1", bus.state_dbg); end
  endtask

  task automatic test_button;
    int   n;
    logic ok;
    bring_up(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL btn_bring_up: got %b want 1", ok); end
    repeat (3) begin
      bus.btn_reset = 1'b1;
      step(1);
      bus.btn_reset = 1'b0;
      step(1);
    end
    step(4);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL btn_bounce_no_abort: got %b want 1", bus.ready); end
    bus.btn_reset = 1'b1;
    step(6);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL btn_before_accept: got %b want 1", bus.ready); end
    bus.btn_reset = 1'b0;
    step(1);
    tests++; if ({bus.ready, bus.core_resetn} !== 2'b00) begin fails++; $display("FAIL btn_press_abort: got %b want 00", {bus.ready, bus.core_resetn}); end
    bus.sdram_init_done = 1'b0;
    step(5);
    tests++; if (bus.state_dbg !== 3'd1) begin fails++; $display("FAIL btn_hold_wait_lock: got %0d want 1", bus.state_dbg); end
    // Debounced level falls on edge 12; lock count 13..19, req at edge 21.
    wait_level(SEL_REQ, 1'b1, 40, n);
    tests++; if (n !== 9) begin fails++; $display("FAIL btn_release_req: got %0d want 9", n); end
  endtask

  task automatic test_stale_done;
    int n;
    apply_reset(1'b1);
    wait_level(SEL_REQ, 1'b1, 40, n);
    tests++; if (n !== 11) begin fails++; $display("FAIL stale_req_latency: got %0d want 11", n); end
    step(1);
    tests++; if ({bus.state_dbg, bus.sdram_init_req} !== {3'd2, 1'b1}) begin fails++; $display("FAIL stale_done_ignored: got state %0d req %b want state 2 req 1", bus.state_dbg, bus.sdram_init_req); end
    step(1);
    tests++; if (bus.state_dbg !== 3'd3) begin fails++; $display("FAIL stale_core_hold: got %0d want 3", bus.state_dbg); end
    resetn = 1'b0;
    #1;
    tests++; if (bus.state_dbg !== 3'd0) begin fails++; $display("FAIL async_reset_state: got %0d want 0", bus.state_dbg); end
    tests++; if ({bus.sdram_init_req, bus.core_resetn, bus.ready, bus.fault} !== 4'b0000) begin fails++; $display("FAIL async_reset_outputs: got %b want 0000", {bus.sdram_init_req, bus.core_resetn, bus.ready, bus.fault}); end
  endtask

  initial begin
    bus.pll_lock        = 1'b1;
    bus.btn_reset       = 1'b0;
    bus.sdram_init_done = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_lock_loss();
    test_init_timeout();
    test_button();
    test_stale_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
